vga_timing_pipe: RTL and testbench

Parametrised VGA timing generator with a video-alignment pipeline. It is the successor to the fixed sync-pulse and porch pair that sits between the game logic and the VGA pins. It generates column and row counters, sync pulses with configurable porches and polarity, active-video and frame/line strobes. It delays sync and active by a configurable number of cycles so that they line up with video from a pipelined renderer, and it blanks video outside the active area.

---
 rtl/vga_timing_pipe.sv | 162 ++++++++++++++++
 tb/tb_vga_timing_pipe.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_pipe.sv
// VGA timing generator: column/row counters, sync/active decode, and a
// configurable delay so sync and blanking line up with a pipelined renderer.

module vga_blank_lane #(
  parameter int VEC_W = 3
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             act,
  input  logic [VEC_W-1:0] vid_in,
  output logic [VEC_W-1:0] vid_out
);
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) vid_out <= '0;
    else         vid_out <= act ? vid_in : '0;
  end
endmodule

module vga_timing_pipe #(
  parameter int VIDEO_WIDTH   = 3,
  parameter int ACTIVE_COLS   = 640,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK_PORCH  = 48,
  parameter int ACTIVE_ROWS   = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK_PORCH  = 33,
  parameter bit HSYNC_POL     = 1'b0,
  parameter bit VSYNC_POL     = 1'b0,
  parameter int PIPE_DELAY    = 2,
  localparam int TOTAL_COLS = ACTIVE_COLS + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH,
  localparam int TOTAL_ROWS = ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH,
  localparam int CW = $clog2(TOTAL_COLS),
  localparam int RW = $clog2(TOTAL_ROWS)
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_Enable,
  output logic [CW-1:0]          o_Col_Count,
  output logic [RW-1:0]          o_Row_Count,
  output logic                   o_Line_Start,
  output logic                   o_Frame_Start,
  input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic                   o_Active,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video
);

  localparam int NUM_LANES = 3;

  localparam logic [CW-1:0] COL_LAST = CW'(TOTAL_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(TOTAL_ROWS - 1);
  localparam logic [CW-1:0] COL_ACT  = CW'(ACTIVE_COLS);
  localparam logic [RW-1:0] ROW_ACT  = RW'(ACTIVE_ROWS);
  localparam logic [CW-1:0] HS_BEG   = CW'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [CW-1:0] HS_END   = CW'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC);
  localparam logic [RW-1:0] VS_BEG   = RW'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [RW-1:0] VS_END   = RW'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC);

  if (PIPE_DELAY < 0 || PIPE_DELAY > 8) begin : g_bad_delay
    $error("vga_timing_pipe: PIPE_DELAY must be 0..8");
  end
  if (VIDEO_WIDTH == 0 || ACTIVE_COLS == 0 || H_FRONT_PORCH == 0 || H_SYNC == 0 ||
      H_BACK_PORCH == 0 || ACTIVE_ROWS == 0 || V_FRONT_PORCH == 0 || V_SYNC == 0 ||
      V_BACK_PORCH == 0) begin : g_bad_zero
    $error("vga_timing_pipe: timing parameters must be non-zero");
  end

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } sync_t;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          run;
  sync_t         dec;
  sync_t         tap;

  // Strobes and decode are qualified by run so a held/idle block reads as blank.
  assign run = i_Enable & i_Rst_L;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      col <= '0;
      row <= '0;
    end else if (!i_Enable) begin
      col <= '0;
      row <= '0;
    end else if (col == COL_LAST) begin
      col <= '0;
      row <= (row == ROW_LAST) ? '0 : row + RW'(1);
    end else begin
      col <= col + CW'(1);
    end
  end

  assign o_Col_Count   = col;
  assign o_Row_Count   = row;
  assign o_Line_Start  = run && (col == '0);
  assign o_Frame_Start = run && (col == '0) && (row == '0);

  always_comb begin
    dec     = '0;
    dec.hs  = run && (col >= HS_BEG) && (col < HS_END);
    dec.vs  = run && (row >= VS_BEG) && (row < VS_END);
    dec.act = run && (col < COL_ACT) && (row < ROW_ACT);
  end

  if (PIPE_DELAY == 0) begin : g_no_pipe
    assign tap = dec;
  end else begin : g_pipe
    sync_t [PIPE_DELAY-1:0] sync_pipe;
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        sync_pipe <= '0;
      end else begin
        sync_pipe[0] <= dec;
        for (int i = 1; i < PIPE_DELAY; i++) sync_pipe[i] <= sync_pipe[i-1];
      end
    end
    assign tap = sync_pipe[PIPE_DELAY-1];
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_HSync  <= ~HSYNC_POL;
      o_VSync  <= ~VSYNC_POL;
      o_Active <= 1'b0;
    end else begin
      o_HSync  <= tap.hs ? HSYNC_POL : ~HSYNC_POL;
      o_VSync  <= tap.vs ? VSYNC_POL : ~VSYNC_POL;
      o_Active <= tap.act;
    end
  end

  // Lane 0 = red, 1 = green, 2 = blue; video is captured alongside the aligned flags.
  logic [NUM_LANES-1:0][VIDEO_WIDTH-1:0] vid_in, vid_out;
  assign vid_in = {i_Blu_Video, i_Grn_Video, i_Red_Video};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    vga_blank_lane #(.VEC_W(VIDEO_WIDTH)) u_lane (
      .gclk    (i_Clk),
      .grst_n  (i_Rst_L),
      .act     (tap.act),
      .vid_in  (vid_in[l]),
      .vid_out (vid_out[l])
    );
  end

  assign o_Red_Video = vid_out[0];
  assign o_Grn_Video = vid_out[1];
  assign o_Blu_Video = vid_out[2];

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Directed bench: default 640x480 instance plus a tiny positive-polarity,
// zero-delay instance checked cycle by cycle against hand-derived timing.

module tb_vga_timing_pipe;

  logic       clk;
  logic       rst_n, en;
  logic [2:0] red, grn, blu;
  logic [9:0] col, row;
  logic       ls, fs, hs, vs, act;
  logic [2:0] o_red, o_grn, o_blu;

  logic       s_rst_n, s_en;
  logic [2:0] s_red, s_zero;
  logic [2:0] s_col, s_row;
  logic       s_ls, s_fs, s_hs, s_vs, s_act;
  logic [2:0] s_ored, s_ogrn, s_oblu;

  int n_cmp = 0;
  int n_bad = 0;

  vga_timing_pipe u_dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en),
    .o_Col_Count(col), .o_Row_Count(row),
    .o_Line_Start(ls), .o_Frame_Start(fs),
    .i_Red_Video(red), .i_Grn_Video(grn), .i_Blu_Video(blu),
    .o_HSync(hs), .o_VSync(vs), .o_Active(act),
    .o_Red_Video(o_red), .o_Grn_Video(o_grn), .o_Blu_Video(o_blu)
  );

  vga_timing_pipe #(
    .VIDEO_WIDTH(3), .ACTIVE_COLS(4), .H_FRONT_PORCH(2), .H_SYNC(1), .H_BACK_PORCH(1),
    .ACTIVE_ROWS(3), .V_FRONT_PORCH(1), .V_SYNC(1), .V_BACK_PORCH(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE_DELAY(0)
  ) u_small (
    .i_Clk(clk), .i_Rst_L(s_rst_n), .i_Enable(s_en),
    .o_Col_Count(s_col), .o_Row_Count(s_row),
    .o_Line_Start(s_ls), .o_Frame_Start(s_fs),
    .i_Red_Video(s_red), .i_Grn_Video(s_zero), .i_Blu_Video(s_zero),
    .o_HSync(s_hs), .o_VSync(s_vs), .o_Active(s_act),
    .o_Red_Video(s_ored), .o_Grn_Video(s_ogrn), .o_Blu_Video(s_oblu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Default-geometry expectations for the count index m (cycles since frame start).
  function automatic logic d_act(int m);
    int c = m % 800;
    int r = (m / 800) % 525;
    return (c < 640) && (r < 480);
  endfunction
  function automatic logic d_hs_lvl(int m);
    int c = m % 800;
    return !((c >= 656) && (c < 752));
  endfunction
  function automatic logic d_vs_lvl(int m);
    int r = (m / 800) % 525;
    return !((r >= 490) && (r < 492));
  endfunction

  initial begin
    int fs_cnt, hs_low, hs_first, act_cnt;
    logic ea;
    rst_n = 1'b0; en = 1'b1; red = 3'd7; grn = 3'd0; blu = 3'd0;
    s_rst_n = 1'b0; s_en = 1'b1; s_red = 3'd5; s_zero = 3'd0;
    repeat (3) @(negedge clk);
    #1;

    // Reset state of both instances
    check("rst_col", col, 0);
    check("rst_row", row, 0);
    check("rst_hsync", hs, 1);
    check("rst_vsync", vs, 1);
    check("rst_active", act, 0);
    check("rst_red", o_red, 0);
    check("rst_grn", o_grn, 0);
    check("rst_fs", fs, 0);
    check("rst_ls", ls, 0);
    check("s_rst_hsync", s_hs, 0);
    check("s_rst_vsync", s_vs, 0);

    // Small config: 8 cols x 6 rows, 1-cycle latency, active-high syncs
    s_rst_n = 1'b1;
    #1;
    fs_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      check("s_col", s_col, k % 8);
      check("s_row", s_row, (k / 8) % 6);
      check("s_fs", s_fs, (k % 48) == 0);
      check("s_ls", s_ls, (k % 8) == 0);
      if (s_fs) fs_cnt++;
      if (k == 0) begin
        check("s_hs0", s_hs, 0);
        check("s_act0", s_act, 0);
      end else begin
        ea = ((k - 1) % 8 < 4) && (((k - 1) / 8) % 6 < 3);
        check("s_hs", s_hs, ((k - 1) % 8) == 6);
        check("s_vs", s_vs, (((k - 1) / 8) % 6) == 4);
        check("s_act", s_act, ea);
        check("s_red", s_ored, ea ? 5 : 0);
      end
      @(negedge clk); #1;
    end
    check("s_fs_count", fs_cnt, 3);
    s_rst_n = 1'b0;

    // Default config: release and check the first two lines cycle by cycle
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    hs_low = 0; hs_first = -1; act_cnt = 0;
    for (int n = 0; n < 1700; n++) begin
      check("col", col, n % 800);
      check("row", row, n / 800);
      check("ls", ls, (n % 800) == 0);
      check("fs", fs, n == 0);
      if (n < 3) begin
        check("hs_pre", hs, 1);
        check("act_pre", act, 0);
        check("red_pre", o_red, 0);
      end else begin
        ea = d_act(n - 3);
        check("hsync", hs, d_hs_lvl(n - 3));
        check("vsync", vs, d_vs_lvl(n - 3));
        check("active", act, ea);
        check("red", o_red, ea ? 7 : 0);
        check("grn", o_grn, ea ? ((n - 3) % 800) % 8 : 0);
        check("blu", o_blu, 0);
      end
      if (n < 800 && hs == 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = n;
      end
      if (n >= 3 && n < 803 && act) act_cnt++;
      grn = (n >= 2) ? 3'(((n - 2) % 800) % 8) : 3'd0;
      @(negedge clk); #1;
    end
    check("hs_first", hs_first, 659);
    check("hs_width", hs_low, 96);
    check("act_per_line", act_cnt, 640);

    // Enable drop at col 300, row 10
    repeat (8300 - 1700) @(negedge clk);
    #1;
    check("pre_drop_col", col, 300);
    check("pre_drop_row", row, 10);
    en = 1'b0;
    @(negedge clk); #1;
    check("drop_col", col, 0);
    check("drop_row", row, 0);
    check("drop_fs", fs, 0);
    check("drop_ls", ls, 0);
    check("drop_act1", act, 1);
    @(negedge clk); #1;
    check("drop_act2", act, 1);
    check("drop_red2", o_red, 7);
    @(negedge clk); #1;
    check("drop_act3", act, 0);
    check("drop_red3", o_red, 0);
    check("drop_hs3", hs, 1);
    repeat (3) @(negedge clk);
    #1;
    check("idle_col", col, 0);
    check("idle_fs", fs, 0);
    en = 1'b1;
    #1;
    check("reen_fs", fs, 1);
    check("reen_col", col, 0);
    @(negedge clk); #1;
    check("reen_col1", col, 1);
    check("reen_fs1", fs, 0);

    // Async reset between edges mid-frame
    repeat (16099) @(negedge clk);
    #1;
    check("mid_col", col, 100);
    check("mid_row", row, 20);
    check("mid_act", act, 1);
    check("mid_red", o_red, 7);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_col", col, 0);
    check("arst_row", row, 0);
    check("arst_act", act, 0);
    check("arst_red", o_red, 0);
    check("arst_hs", hs, 1);
    check("arst_vs", vs, 1);
    check("arst_fs", fs, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_fs", fs, 1);
    check("rel_col", col, 0);
    @(negedge clk); #1;
    check("rel_col1", col, 1);
    check("rel_act1", act, 0);
    @(negedge clk); #1;
    check("rel_act2", act, 0);
    check("rel_red2", o_red, 0);
    @(negedge clk); #1;
    check("rel_act3", act, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
